// File: rtl/rot_vec_mul.sv
// rot_vec_mul: vec_out = R * vec_in through one sequential FP multiply-add over 9 cycles.
// Optional ROT_VEC_TRANSPOSE_EN adds a transpose input selecting R^T * vec_in.
module rot_vec_mul #(
   parameter int SIG_WIDTH       = 23,
   parameter int EXP_WIDTH       = 8,
   parameter int IEEE_COMPLIANCE = 0,
   parameter int DATA_WIDTH      = SIG_WIDTH + EXP_WIDTH + 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
`ifdef ROT_VEC_TRANSPOSE_EN
   input  logic                                transpose,
`endif
   input  logic [2:0][2:0][DATA_WIDTH-1:0]     mat_in,
   input  logic [2:0][DATA_WIDTH-1:0]          vec_in,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [2:0][DATA_WIDTH-1:0]          vec_out
);

   localparam int SW   = SIG_WIDTH;
   localparam int EW   = EXP_WIDTH;
   localparam int F    = 2 * SW;
   localparam int MW   = F + 2;
   localparam int N    = F + 5;
   localparam int BIAS = (1 << (EW - 1)) - 1;
   localparam int EMAX = (1 << EW) - 1;

   // Fused a*b + c with a single RNE rounding; denormal inputs/results flush to zero.
   function automatic logic [DATA_WIDTH-1:0] fp_mac(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b,
                                                   input logic [DATA_WIDTH-1:0] c);
      logic          sa, sb, sc, sp, sr, s_big, s_sml, zp, zc, ip, ic, g, st;
      logic [EW-1:0] ea, eb, ec;
      logic [SW:0]   ma, mb, mc;
      logic [MW-1:0] mp, mcx;
      logic [N-1:0]  big, sml, sh, mask;
      logic [N:0]    sum, norm;
      logic [SW+1:0] mr;
      int            ep, ecc, e_big, d, p, er;
      sa = a[DATA_WIDTH-1]; ea = a[DATA_WIDTH-2 -: EW]; ma = {1'b1, a[SW-1:0]};
      sb = b[DATA_WIDTH-1]; eb = b[DATA_WIDTH-2 -: EW]; mb = {1'b1, b[SW-1:0]};
      sc = c[DATA_WIDTH-1]; ec = c[DATA_WIDTH-2 -: EW]; mc = {1'b1, c[SW-1:0]};
      zp = (ea == '0) || (eb == '0);
      zc = (ec == '0);
      ip = (ea == '1) || (eb == '1);
      ic = (ec == '1);
      sp = sa ^ sb;
      if (ip || ic) begin
         if (IEEE_COMPLIANCE != 0 && ip && ic && (sp != sc))
            return {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};
         return {ip ? sp : sc, {EW{1'b1}}, {SW{1'b0}}};
      end
      if (zp && zc) return {sp & sc, {(DATA_WIDTH-1){1'b0}}};
      mp  = zp ? '0 : MW'(ma) * MW'(mb);
      ep  = zp ? -100000 : int'(ea) + int'(eb) - BIAS;
      mcx = zc ? '0 : {1'b0, mc, {SW{1'b0}}};
      ecc = zc ? -100000 : int'(ec);
      if (ep >= ecc) begin
         big = {mp, 3'b000};  sml = {mcx, 3'b000}; s_big = sp; s_sml = sc; e_big = ep;  d = ep - ecc;
      end else begin
         big = {mcx, 3'b000}; sml = {mp, 3'b000};  s_big = sc; s_sml = sp; e_big = ecc; d = ecc - ep;
      end
      // Bits shifted past the guard positions collapse into a sticky LSB.
      if (d >= N) begin
         sh    = '0;
         sh[0] = |sml;
      end else begin
         mask  = ~({N{1'b1}} << d);
         sh    = sml >> d;
         sh[0] = sh[0] | (|(sml & mask));
      end
      if (s_big == s_sml) begin
         sum = {1'b0, big} + {1'b0, sh}; sr = s_big;
      end else if (big >= sh) begin
         sum = {1'b0, big - sh};         sr = s_big;
      end else begin
         sum = {1'b0, sh - big};         sr = s_sml;
      end
      if (sum == '0) return '0;
      p = 0;
      for (int i = 0; i <= N; i++) if (sum[i]) p = i;
      norm = sum << (N - p);
      er   = e_big + p - (F + 3);
      mr   = {1'b0, norm[N -: SW+1]};
      g    = norm[N-SW-1];
      st   = |norm[N-SW-2:0];
      mr   = mr + {{(SW+1){1'b0}}, g & (st | mr[0])};
      if (mr[SW+1]) begin
         er = er + 1;
         mr = mr >> 1;
      end
      if (er >= EMAX) return {sr, {EW{1'b1}}, {SW{1'b0}}};
      if (er <= 0)    return {sr, {(DATA_WIDTH-1){1'b0}}};
      return {sr, er[EW-1:0], mr[SW-1:0]};
   endfunction

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t                            state_q;
   logic [2:0][2:0][DATA_WIDTH-1:0]   mat_q;
   logic [2:0][DATA_WIDTH-1:0]        vec_q;
   logic [2:0][DATA_WIDTH-1:0]        res_q;
   logic [DATA_WIDTH-1:0]             acc_q;
   logic [DATA_WIDTH-1:0]             acc_d;
   logic [DATA_WIDTH-1:0]             op_m;
   logic [1:0]                        row_q;
   logic [1:0]                        col_q;
   logic                              out_valid_q;

`ifdef ROT_VEC_TRANSPOSE_EN
   logic tr_q;
   assign op_m = tr_q ? mat_q[col_q][row_q] : mat_q[row_q][col_q];
`else
   assign op_m = mat_q[row_q][col_q];
`endif

   assign acc_d     = fp_mac(op_m, vec_q[col_q], acc_q);
   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign vec_out   = res_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mat_q       <= '0;
         vec_q       <= '0;
         res_q       <= '0;
         acc_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         out_valid_q <= 1'b0;
`ifdef ROT_VEC_TRANSPOSE_EN
         tr_q        <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mat_q   <= mat_in;
                  vec_q   <= vec_in;
                  row_q   <= '0;
                  col_q   <= '0;
                  acc_q   <= '0;
`ifdef ROT_VEC_TRANSPOSE_EN
                  tr_q    <= transpose;
`endif
                  state_q <= COMPUTE;
               end
            end
            COMPUTE: begin
               // Row result retires on its third product; accumulator restarts at +0.
               if (col_q == 2'd2) begin
                  res_q[row_q] <= acc_d;
                  acc_q        <= '0;
                  col_q        <= '0;
                  if (row_q == 2'd2) begin
                     row_q       <= '0;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     row_q <= row_q + 2'd1;
                  end
               end else begin
                  acc_q <= acc_d;
                  col_q <= col_q + 2'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rot_vec_mul.sv
// Directed bench for rot_vec_mul: reset, rotations, rounding, backpressure, throughput,
// mid-transaction reset and operand capture.
module tb_rot_vec_mul;

   typedef logic [2:0][2:0][31:0] mat_t;
   typedef logic [2:0][31:0]      vec_t;

   localparam logic [31:0] Z  = 32'h0000_0000;
   localparam logic [31:0] P1 = 32'h3F80_0000;
   localparam logic [31:0] N1 = 32'hBF80_0000;
   localparam logic [31:0] P2 = 32'h4000_0000;
   localparam logic [31:0] N2 = 32'hC000_0000;
   localparam logic [31:0] P3 = 32'h4040_0000;
   localparam logic [31:0] P6 = 32'h40C0_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, in_valid, in_ready, out_valid, out_ready;
   mat_t mat_in;
   vec_t vec_in, vec_out;
`ifdef ROT_VEC_TRANSPOSE_EN
   logic transpose;
`endif

   int total = 0;
   int bad   = 0;

   rot_vec_mul #(.SIG_WIDTH(23), .EXP_WIDTH(8), .IEEE_COMPLIANCE(0), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
`ifdef ROT_VEC_TRANSPOSE_EN
      .transpose(transpose),
`endif
      .mat_in(mat_in), .vec_in(vec_in), .out_valid(out_valid), .out_ready(out_ready),
      .vec_out(vec_out)
   );

   function automatic vec_t mk3(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
      return {a2, a1, a0};
   endfunction

   function automatic mat_t mkm(input vec_t r0, input vec_t r1, input vec_t r2);
      return {r2, r1, r0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input mat_t m, input vec_t v, input string tag);
      int n = 0;
      mat_in   = m;
      vec_in   = v;
      in_valid = 1'b1;
      while (!in_ready && n < 30) begin step(); n++; end
      chk({tag, " accept"}, 32'(n < 30), 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   // Waits for out_valid right after an accept; optionally scrambles the inputs meanwhile.
   task automatic collect(input vec_t e, input string tag, input bit scramble);
      int lat = 1;
      while (!out_valid && lat < 40) begin
         if (scramble) begin
            for (int r = 0; r < 3; r++) begin
               vec_in[r] = $urandom;
               for (int c = 0; c < 3; c++) mat_in[r][c] = $urandom;
            end
            in_valid = 1'($urandom_range(0, 1));
         end
         step();
         lat++;
      end
      in_valid = 1'b0;
      chk({tag, " latency"}, 32'(lat), 32'd10);
      for (int r = 0; r < 3; r++) chk($sformatf("%s vec_out[%0d]", tag, r), vec_out[r], e[r]);
   endtask

   mat_t ident, rz, ones, mixed, rnd;
   vec_t v1, vx;
   mat_t ms[3];
   vec_t es[3];
   int   acc_cyc[3];

   initial begin
      ident = mkm(mk3(P1, Z, Z), mk3(Z, P1, Z), mk3(Z, Z, P1));
      rz    = mkm(mk3(Z, N1, Z), mk3(P1, Z, Z), mk3(Z, Z, P1));
      ones  = mkm(mk3(P1, P1, P1), mk3(P1, P1, P1), mk3(P1, P1, P1));
      mixed = mkm(mk3(P2, Z, Z), mk3(Z, N1, Z), mk3(P1, P1, N1));
      rnd   = mkm(mk3(P1, P1, Z), mk3(P1, Z, P1), mk3(P1, Z, Z));
      v1    = mk3(P1, P2, P3);
      vx    = mk3(P1, Z, Z);

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      mat_in    = '0;
      vec_in    = '0;
`ifdef ROT_VEC_TRANSPOSE_EN
      transpose = 1'b0;
`endif
      #12;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      for (int r = 0; r < 3; r++) chk($sformatf("reset vec_out[%0d]", r), vec_out[r], Z);
      rst_n = 1'b1;
      step();

      // Identity
      send(ident, v1, "t1");
      collect(v1, "t1", 1'b0);
      step();

      // Rz(90)
      send(rz, vx, "t2");
      collect(mk3(Z, P1, Z), "t2", 1'b0);
      step();
`ifdef ROT_VEC_TRANSPOSE_EN
      transpose = 1'b1;
      send(rz, vx, "t2T");
      transpose = 1'b0;
      collect(mk3(Z, N1, Z), "t2T", 1'b0);
      step();
`endif

      // RNE: 1+2^-24 is a tie to even, 1+1.5ulp rounds up
      send(rnd, mk3(P1, 32'h3380_0000, 32'h3440_0000), "trnd");
      collect(mk3(P1, 32'h3F80_0002, P1), "trnd", 1'b0);
      step();

      // Backpressure in DONE; a pending in_valid must not be accepted
      out_ready = 1'b0;
      send(ident, v1, "t3");
      collect(v1, "t3", 1'b0);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3 hold out_valid", 32'(out_valid), 32'd1);
         chk("t3 hold in_ready", 32'(in_ready), 32'd0);
         for (int r = 0; r < 3; r++) chk($sformatf("t3 hold vec_out[%0d]", r), vec_out[r], v1[r]);
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t3 release out_valid", 32'(out_valid), 32'd0);
      chk("t3 release in_ready", 32'(in_ready), 32'd1);
      step();

      // Back-to-back with in_valid held high
      ms[0] = ident; es[0] = v1;
      ms[1] = ones;  es[1] = mk3(P6, P6, P6);
      ms[2] = mixed; es[2] = mk3(P2, N2, Z);
      begin
         int k = 0;
         int j = 0;
         in_valid = 1'b1;
         for (int cyc = 0; cyc < 60 && j < 3; cyc++) begin
            if (out_valid) begin
               for (int r = 0; r < 3; r++) chk($sformatf("t4 res%0d[%0d]", j, r), vec_out[r], es[j][r]);
               j++;
            end
            if (in_ready && k < 3) begin
               mat_in     = ms[k];
               vec_in     = v1;
               acc_cyc[k] = cyc;
               k++;
            end
            step();
         end
         in_valid = 1'b0;
         chk("t4 results", 32'(j), 32'd3);
         chk("t4 spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd11);
         chk("t4 spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd11);
      end
      step();

      // Reset in COMPUTE cycle 4
      send(ident, v1, "t5");
      step(); step(); step();
      rst_n = 1'b0;
      #1;
      chk("t5 rst out_valid", 32'(out_valid), 32'd0);
      chk("t5 rst in_ready", 32'(in_ready), 32'd1);
      for (int r = 0; r < 3; r++) chk($sformatf("t5 rst vec_out[%0d]", r), vec_out[r], Z);
      #2;
      rst_n = 1'b1;
      step();
      send(ident, v1, "t5b");
      collect(v1, "t5b", 1'b0);
      step();

      // Inputs change every cycle after accept
      send(mixed, v1, "t6");
      collect(mk3(P2, N2, Z), "t6", 1'b1);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
